// File: rtl/boa_arb_pkg.sv
// Shared types and widths for the boa memory-port arbiter.
package boa_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int REQ_W = 32;
    localparam int WE_W  = 4;

endpackage

// File: rtl/boa_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module boa_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [PW-1:0]   pick_idx,
    output logic            valid
);

    always_comb begin
        int idx;
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                pick_idx  = PW'(idx);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/boa_mem_arbiter.sv
// Round-robin arbiter sharing one memory slave port between NREQ requesters,
// with a registered grant and an optional timeout that aborts a hung slave.
module boa_mem_arbiter
    import boa_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_re,
    input  logic [NREQ-1:0][WE_W-1:0]   req_we,
    input  logic [NREQ-1:0][REQ_W-1:0]  req_addr,
    input  logic [NREQ-1:0][REQ_W-1:0]  req_wdata,
    output logic [NREQ-1:0][REQ_W-1:0]  req_rdata,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             req_err,
    output logic                        mem_re,
    output logic [WE_W-1:0]             mem_we,
    output logic [REQ_W-1:0]            mem_addr,
    output logic [REQ_W-1:0]            mem_wdata,
    input  logic [REQ_W-1:0]            mem_rdata,
    input  logic                        mem_ready,
    output logic [NREQ-1:0]             grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] req_active;
    logic [NREQ-1:0] pick;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;
    logic            timeout_hit;
    logic            done;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_active[gi] = req_re[gi] | (|req_we[gi]);
            assign req_rdata[gi]  = mem_rdata;
        end
    endgenerate

    boa_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req      (req_active),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    assign grant       = grant_q;
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    // Memory side follows the registered owner; everything is zero outside BUSY.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ARB_BUSY) begin
            mem_re    = req_re[gidx_q];
            mem_we    = req_we[gidx_q];
            mem_addr  = req_addr[gidx_q];
            mem_wdata = req_wdata[gidx_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        req_err   = '0;
        done      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_BUSY;
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_BUSY: begin
                // An abandoned request ends the transaction silently; ready beats timeout.
                if (!req_active[gidx_q]) begin
                    done = 1'b1;
                end else if (mem_ready) begin
                    req_ready[gidx_q] = 1'b1;
                    done              = 1'b1;
                end else if (timeout_hit) begin
                    req_err[gidx_q] = 1'b1;
                    done            = 1'b1;
                end else if (TO_EN && (cnt_q != TO_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
